// File: rtl/dunit_pkg.sv
// Shared definitions for the debug-unit controller: host command bytes,
// status bytes and the controller state encoding.
package dunit_pkg;

   localparam logic [7:0] CMD_LOAD  = 8'h4C;
   localparam logic [7:0] CMD_CONT  = 8'h43;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_RSTPC = 8'h52;

   localparam logic [7:0] STAT_ACK  = 8'hAA;
   localparam logic [7:0] STAT_ERR  = 8'hEE;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LD_CNT,
      ST_LD_BYTE,
      ST_LD_WR,
      ST_RUN,
      ST_STEP,
      ST_DMP_ADDR,
      ST_DMP_CAP,
      ST_DMP_TX,
      ST_ACK
   } state_t;

   // States in which the controller takes bytes from the host link.
   function automatic logic rx_state(input state_t s);
      return s inside {ST_IDLE, ST_LD_CNT, ST_LD_BYTE};
   endfunction

endpackage

// File: rtl/dunit_ctrl_if.sv
// Host-link and pipeline debug-port signals of the debug unit.
// master: the controller; slave: the UART FIFOs plus the pipeline.
interface dunit_ctrl_if #(
   parameter int NB_REG  = 32,
   parameter int NB_BYTE = 8
);
   logic [NB_BYTE-1:0] i_rx_data;
   logic               i_rx_valid;
   logic               o_rx_ready;
   logic [NB_BYTE-1:0] o_tx_data;
   logic               o_tx_valid;
   logic               i_tx_ready;
   logic               o_dunit_clk_en;
   logic               o_dunit_reset_pc;
   logic               o_dunit_w_mem;
   logic [NB_REG-1:0]  o_dunit_addr;
   logic [NB_REG-1:0]  o_dunit_data_if;
   logic [NB_REG-1:0]  i_dunit_reg;
   logic [NB_REG-1:0]  i_dunit_mem_data;
   logic [NB_REG-1:0]  i_pc;
   logic               i_halt;

   modport master (
      input  i_rx_data, i_rx_valid, i_tx_ready,
      input  i_dunit_reg, i_dunit_mem_data, i_pc, i_halt,
      output o_rx_ready, o_tx_data, o_tx_valid,
      output o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
      output o_dunit_addr, o_dunit_data_if
   );

   modport slave (
      output i_rx_data, i_rx_valid, i_tx_ready,
      output i_dunit_reg, i_dunit_mem_data, i_pc, i_halt,
      input  o_rx_ready, o_tx_data, o_tx_valid,
      input  o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
      input  o_dunit_addr, o_dunit_data_if
   );
endinterface

// File: rtl/dunit_word_ser.sv
// Word-to-byte serializer: sends a captured word MSB-first over a
// valid/ready byte port; the byte on tx_data holds while stalled.
module dunit_word_ser #(
   parameter int NB_WORD = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NB_WORD-1:0] word,
   input  logic               load,
   output logic [NB_BYTE-1:0] tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               last
);
   localparam int N_BYTES = NB_WORD / NB_BYTE;
   localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);

   logic [NB_WORD-1:0] sh_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               valid_q;

   // Capture on load, shift one byte out per accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         sh_q    <= word;
         cnt_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && tx_ready) begin
         sh_q  <= sh_q << NB_BYTE;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) valid_q <= 1'b0;
      end
   end

   assign tx_valid = valid_q;
   assign tx_data  = valid_q ? sh_q[NB_WORD-1 -: NB_BYTE] : '0;
   assign last     = valid_q && tx_ready && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dunit_ctrl.sv
// Debug-unit controller: decodes host commands to load instruction memory,
// run or single-step the pipeline, and dump PC, registers and data memory.
module dunit_ctrl
   import dunit_pkg::*;
#(
   parameter int NB_REG     = 32,
   parameter int NB_BYTE    = 8,
   parameter int N_REGS     = 32,
   parameter int N_MEM_DUMP = 16,
   parameter int MAX_CYCLES = 1024
) (
   input  logic         i_clk,
   input  logic         i_reset,
   dunit_ctrl_if.master bus
);
   localparam int N_WORDS = 1 + N_REGS + N_MEM_DUMP;
   localparam int IDX_W   = $clog2(N_WORDS + 1);
   localparam int CYC_W   = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

   state_t             state_q, state_d;
   logic               rstpc_cmd;
   logic               rx_fire;
   logic               rx_ready_q;
   logic               reset_pc_q;
   logic [7:0]         cnt_n_q;
   logic [7:0]         k_q;
   logic [1:0]         byte_cnt_q;
   logic [NB_REG-1:0]  shift_q;
   logic [CYC_W-1:0]   cyc_q;
   logic [IDX_W-1:0]   idx_q;
   logic [7:0]         status_q;
   logic [NB_REG-1:0]  dmp_addr;
   logic [NB_REG-1:0]  cap_word;
   logic [NB_REG-1:0]  idx_ext;
   logic [NB_BYTE-1:0] ser_data;
   logic               ser_valid;
   logic               ser_last;

   assign rx_fire = bus.i_rx_valid && rx_ready_q;

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state decode from host bytes, run limits and dump progress.
   always_comb begin
      state_d   = state_q;
      rstpc_cmd = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_fire) begin
               case (bus.i_rx_data)
                  CMD_LOAD:  state_d = ST_LD_CNT;
                  CMD_CONT:  state_d = ST_RUN;
                  CMD_STEP:  state_d = ST_STEP;
                  CMD_RSTPC: begin
                     state_d   = ST_ACK;
                     rstpc_cmd = 1'b1;
                  end
                  default:   state_d = ST_ACK;
               endcase
            end
         end
         ST_LD_CNT:   if (rx_fire) state_d = (bus.i_rx_data == '0) ? ST_ACK : ST_LD_BYTE;
         ST_LD_BYTE:  if (rx_fire && byte_cnt_q == 2'd3) state_d = ST_LD_WR;
         ST_LD_WR:    state_d = ((k_q + 8'd1) < cnt_n_q) ? ST_LD_BYTE : ST_ACK;
         ST_RUN:      if (bus.i_halt || cyc_q == CYC_LAST) state_d = ST_DMP_ADDR;
         ST_STEP:     state_d = ST_DMP_ADDR;
         ST_DMP_ADDR: state_d = ST_DMP_CAP;
         ST_DMP_CAP:  state_d = ST_DMP_TX;
         ST_DMP_TX:   if (ser_last) state_d = (idx_q == IDX_LAST) ? ST_ACK : ST_DMP_ADDR;
         ST_ACK:      if (bus.i_tx_ready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Counters, load shift register, status byte and registered strobes.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_ready_q <= 1'b0;
         reset_pc_q <= 1'b0;
         cnt_n_q    <= '0;
         k_q        <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         cyc_q      <= '0;
         idx_q      <= '0;
         status_q   <= '0;
      end else begin
         rx_ready_q <= rx_state(state_d);
         reset_pc_q <= (state_d == ST_LD_WR) || rstpc_cmd;
         case (state_q)
            ST_IDLE: begin
               if (rx_fire) begin
                  status_q <= (state_d == ST_ACK && !rstpc_cmd) ? STAT_ERR : STAT_ACK;
                  cyc_q    <= '0;
               end
            end
            ST_LD_CNT: begin
               if (rx_fire) begin
                  cnt_n_q    <= bus.i_rx_data;
                  k_q        <= '0;
                  byte_cnt_q <= '0;
               end
            end
            ST_LD_BYTE: begin
               if (rx_fire) begin
                  shift_q    <= {shift_q[NB_REG-NB_BYTE-1:0], bus.i_rx_data};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
               end
            end
            ST_LD_WR: begin
               if (state_d == ST_LD_BYTE) k_q <= k_q + 8'd1;
            end
            ST_RUN: begin
               cyc_q <= cyc_q + 1'b1;
               idx_q <= '0;
            end
            ST_STEP:   idx_q <= '0;
            ST_DMP_TX: if (ser_last) idx_q <= idx_q + 1'b1;
            default: ;
         endcase
      end
   end

   // Dump word index 0 is the PC, then registers, then dmem words.
   always_comb begin
      idx_ext  = NB_REG'(idx_q);
      dmp_addr = '0;
      cap_word = bus.i_pc;
      if (idx_q != '0) begin
         if (idx_q <= IDX_W'(N_REGS)) begin
            dmp_addr = idx_ext - NB_REG'(1);
            cap_word = bus.i_dunit_reg;
         end else begin
            dmp_addr = (idx_ext - NB_REG'(N_REGS) - NB_REG'(1)) << 2;
            cap_word = bus.i_dunit_mem_data;
         end
      end
   end

   dunit_word_ser #(
      .NB_WORD (NB_REG),
      .NB_BYTE (NB_BYTE)
   ) u_ser (
      .clk      (i_clk),
      .rst_n    (i_reset),
      .word     (cap_word),
      .load     (state_q == ST_DMP_CAP),
      .tx_data  (ser_data),
      .tx_valid (ser_valid),
      .tx_ready (bus.i_tx_ready),
      .last     (ser_last)
   );

   // Pipeline debug-port address: imem word address on writes, dump address on reads.
   always_comb begin
      bus.o_dunit_addr = '0;
      case (state_q)
         ST_LD_WR:                bus.o_dunit_addr = NB_REG'({k_q, 2'b00});
         ST_DMP_ADDR, ST_DMP_CAP: bus.o_dunit_addr = dmp_addr;
         default: ;
      endcase
   end

   assign bus.o_rx_ready       = rx_ready_q;
   assign bus.o_dunit_reset_pc = reset_pc_q;
   assign bus.o_dunit_w_mem    = (state_q == ST_LD_WR);
   assign bus.o_dunit_clk_en   = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign bus.o_dunit_data_if  = (state_q == ST_LD_WR) ? shift_q : '0;
   assign bus.o_tx_valid       = (state_q == ST_ACK) || ser_valid;
   assign bus.o_tx_data        = (state_q == ST_ACK) ? status_q : ser_data;

endmodule

// File: tb/tb_dunit_ctrl.sv
// Directed bench for dunit_ctrl with a tx-byte / imem-write scoreboard and
// a small pipeline model (PC, register file, data memory).
module tb_dunit_ctrl;
   import dunit_pkg::*;

   localparam int MAXC  = 16;
   localparam int LIMIT = 5000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dunit_ctrl_if #(.NB_REG(32), .NB_BYTE(8)) bus ();

   dunit_ctrl #(
      .NB_REG     (32),
      .NB_BYTE    (8),
      .N_REGS     (32),
      .N_MEM_DUMP (16),
      .MAX_CYCLES (MAXC)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus.master)
   );

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  tx_q [$];
   logic [63:0] wr_q [$];
   int          en_cnt = 0;
   int          halt_target = -1;
   logic [31:0] pc_model = 32'h100;
   bit          bp_mode = 1'b0;
   int unsigned cyc = 0;
   int          base;
   logic [7:0]  load_seq [10];

   function automatic logic [31:0] reg_val(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (r == 5'd3) return 32'h1;
      return 32'hA500_0000 | (32'(r) << 16) | 32'(r);
   endfunction

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return 32'hD00D_0000 ^ a ^ (a << 20);
   endfunction

   // Pipeline model: PC, 1-cycle-latency register/memory reads, run-cycle count.
   always @(posedge clk) begin
      if (bus.o_dunit_clk_en) en_cnt <= en_cnt + 1;
      if (bus.o_dunit_reset_pc)    pc_model <= 32'h0;
      else if (bus.o_dunit_clk_en) pc_model <= pc_model + 32'd4;
      bus.i_dunit_reg      <= reg_val(bus.o_dunit_addr[4:0]);
      bus.i_dunit_mem_data <= mem_val(bus.o_dunit_addr);
      cyc <= cyc + 1;
   end

   assign bus.i_pc   = pc_model;
   assign bus.i_halt = bus.o_dunit_clk_en && (en_cnt == halt_target);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_tx_ready();
      forever begin
         @(posedge clk);
         #1;
         bus.i_tx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
      end
   endtask

   task automatic monitor();
      logic       stall_prev = 1'b0;
      logic [7:0] stall_data = '0;
      logic [7:0] eb;
      logic [63:0] ew;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev)
               check("tx_hold", {bus.o_tx_valid, bus.o_tx_data}, {1'b1, stall_data});
            if (bus.o_tx_valid && bus.i_tx_ready) begin
               check("tx_expected", 64'(tx_q.size() != 0), 64'd1);
               if (tx_q.size() != 0) begin
                  eb = tx_q.pop_front();
                  check("tx_byte", bus.o_tx_data, eb);
               end
            end
            if (bus.o_dunit_w_mem) begin
               check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
               if (wr_q.size() != 0) begin
                  ew = wr_q.pop_front();
                  check("wr_addr", bus.o_dunit_addr, ew[63:32]);
                  check("wr_data", bus.o_dunit_data_if, ew[31:0]);
                  check("wr_rst_pc", bus.o_dunit_reset_pc, 1'b1);
               end
            end
            stall_prev = bus.o_tx_valid && !bus.i_tx_ready;
            stall_data = bus.o_tx_data;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.i_rx_data  = b;
      bus.i_rx_valid = 1'b1;
      while (!bus.o_rx_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("rx_accept", bus.o_rx_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.i_rx_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((tx_q.size() != 0 || wr_q.size() != 0) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(tx_q.size() + wr_q.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) tx_q.push_back(w[8*i +: 8]);
   endtask

   task automatic push_dump(input logic [31:0] pc);
      push_word(pc);
      for (int r = 0; r < 32; r++) push_word(reg_val(5'(r)));
      for (int j = 0; j < 16; j++) push_word(mem_val(32'(4 * j)));
      tx_q.push_back(STAT_ACK);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"}, bus.o_rx_ready, 1'b0);
      check({tag, "_tx_valid"}, bus.o_tx_valid, 1'b0);
      check({tag, "_tx_data"},  bus.o_tx_data, 8'h00);
      check({tag, "_clk_en"},   bus.o_dunit_clk_en, 1'b0);
      check({tag, "_rst_pc"},   bus.o_dunit_reset_pc, 1'b0);
      check({tag, "_w_mem"},    bus.o_dunit_w_mem, 1'b0);
      check({tag, "_addr"},     bus.o_dunit_addr, 32'h0);
      check({tag, "_data_if"},  bus.o_dunit_data_if, 32'h0);
   endtask

   initial begin
      int n;
      bus.i_rx_data  = '0;
      bus.i_rx_valid = 1'b0;
      bus.i_tx_ready = 1'b1;
      load_seq = '{8'h4C, 8'h02, 8'h20, 8'h03, 8'h00, 8'h01, 8'h20, 8'h83, 8'h00, 8'h02};
      fork
         monitor();
         drive_tx_ready();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Load two words.
      wr_q.push_back({32'h0, 32'h2003_0001});
      wr_q.push_back({32'h4, 32'h2083_0002});
      tx_q.push_back(STAT_ACK);
      foreach (load_seq[i]) send_byte(load_seq[i]);
      drain("load_drain");

      // Single step after load: PC 0 -> 4.
      base = en_cnt;
      push_dump(32'h4);
      send_byte(CMD_STEP);
      drain("step_drain");
      check("step_clk_en_cycles", 64'(en_cnt - base), 64'd1);

      // Continuous run halted on run cycle 9, dump under backpressure.
      bp_mode = 1'b1;
      base = en_cnt;
      halt_target = base + 8;
      push_dump(32'h4 + 32'd36);
      send_byte(CMD_CONT);
      drain("halt_drain");
      check("halt_clk_en_cycles", 64'(en_cnt - base), 64'd9);
      halt_target = -1;
      bp_mode = 1'b0;

      // Watchdog stop after MAXC cycles.
      base = en_cnt;
      push_dump(32'd40 + 32'(4 * MAXC));
      send_byte(CMD_CONT);
      drain("wdog_drain");
      check("wdog_clk_en_cycles", 64'(en_cnt - base), 64'(MAXC));

      // Reset PC command.
      tx_q.push_back(STAT_ACK);
      send_byte(CMD_RSTPC);
      drain("rstpc_drain");
      check("rstpc_pc", pc_model, 32'h0);

      // Unknown command.
      tx_q.push_back(STAT_ERR);
      send_byte(8'h7F);
      drain("err_drain");
      check("err_idle_ready", bus.o_rx_ready, 1'b1);

      // Reset in the middle of a dump.
      push_dump(32'h4);
      send_byte(CMD_STEP);
      n = 0;
      while (tx_q.size() > 150 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("middump_reached", 64'(tx_q.size() <= 150), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("middump_rst");
      tx_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_tx_idle", bus.o_tx_valid, 1'b0);

      // Step works normally after the abort: PC 4 -> 8.
      base = en_cnt;
      push_dump(32'h8);
      send_byte(CMD_STEP);
      drain("post_rst_step_drain");
      check("post_rst_step_cycles", 64'(en_cnt - base), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
